// File: rtl/awgn_channel_iq.sv
// awgn_channel_iq: streamed I/Q channel adding scaled pseudo-Gaussian noise, with handshake, SNR select, bypass and clipping
module awgn_channel_iq #(
  parameter int             DW     = 12,
  parameter int             LW     = 16,
  parameter logic [LW-1:0]  SEED   = 16'hACE1,
  parameter int             NSHIFT = 4,
  parameter int             CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x_real,
  input  logic signed [DW-1:0] x_imag,
  input  logic [3:0]           snr_db,
  input  logic                 noise_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] y_real,
  output logic signed [DW-1:0] y_imag,
  output logic                 sat_flag,
  output logic [CNT_W-1:0]     sample_cnt
);
  logic                  w_adv, w_acc;
  logic [7:0][7:0]       w_u;
  logic [7:0]            w_sigma;
  logic signed [9:0]     w_sum_i, w_sum_q;
  logic signed [18:0]    w_p_i, w_p_q;
  logic signed [DW+1:0]  w_y_i, w_y_q;
  logic [DW-1:0]         w_c_i, w_c_q;
  logic                  w_s_i, w_s_q;
  logic                  r_v1, r_v2, r_v3;
  logic signed [DW-1:0]  r_x1_i, r_x1_q, r_x2_i, r_x2_q, r_y_i, r_y_q;
  logic [7:0]            r_sig1;
  logic signed [9:0]     r_sum1_i, r_sum1_q;
  logic signed [DW+1:0]  r_n2_i, r_n2_q;
  logic                  r_sat;
  logic [CNT_W-1:0]      r_cnt;

  function automatic logic signed [9:0] sx(input logic [7:0] u);
    return {{2{u[7]}}, u};
  endfunction

  function automatic logic [DW:0] clip(input logic signed [DW+1:0] y);
    logic hi, lo;
    hi = ~y[DW+1] & (y[DW] | y[DW-1]);
    lo = y[DW+1] & ~(y[DW] & y[DW-1]);
    return {hi | lo, hi ? {1'b0, {(DW-1){1'b1}}} : lo ? {1'b1, {(DW-1){1'b0}}} : y[DW-1:0]};
  endfunction

  assign w_adv     = out_ready | ~out_valid;
  assign in_ready  = w_adv;
  assign w_acc     = in_valid & w_adv;
  assign out_valid = r_v3;
  assign y_real    = r_y_i;
  assign y_imag    = r_y_q;
  assign sat_flag  = r_sat;
  assign sample_cnt = r_cnt;

  for (genvar k = 0; k < 8; k++) begin : g_lfsr
    localparam logic [LW-1:0] SK = (SEED << (2 * k)) | (SEED >> (LW - 2 * k));
    logic [LW-1:0] r_s;
    // each LFSR steps exactly once per accepted sample
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_s <= SK;
      else if (w_acc) r_s <= {r_s[LW-2:0], r_s[15] ^ r_s[13] ^ r_s[12] ^ r_s[10]};
    end
    assign w_u[k] = r_s[7:0];
  end

  assign w_sum_i = noise_en ? sx(w_u[0]) + sx(w_u[1]) + sx(w_u[2]) + sx(w_u[3]) : '0;
  assign w_sum_q = noise_en ? sx(w_u[4]) + sx(w_u[5]) + sx(w_u[6]) + sx(w_u[7]) : '0;

  // noise amplitude per SNR step, Q0.8; anything above 9 dB uses the 9 dB value
  always_comb begin
    case (snr_db)
      4'd0:    w_sigma = 8'd180;
      4'd1:    w_sigma = 8'd161;
      4'd2:    w_sigma = 8'd143;
      4'd3:    w_sigma = 8'd128;
      4'd4:    w_sigma = 8'd114;
      4'd5:    w_sigma = 8'd102;
      4'd6:    w_sigma = 8'd90;
      4'd7:    w_sigma = 8'd81;
      4'd8:    w_sigma = 8'd72;
      default: w_sigma = 8'd64;
    endcase
  end

  // S1: capture the sample, sigma and the raw noise sums
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1     <= 1'b0;
      r_x1_i   <= '0;
      r_x1_q   <= '0;
      r_sig1   <= '0;
      r_sum1_i <= '0;
      r_sum1_q <= '0;
    end else if (w_adv) begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_x1_i   <= x_real;
        r_x1_q   <= x_imag;
        r_sig1   <= w_sigma;
        r_sum1_i <= w_sum_i;
        r_sum1_q <= w_sum_q;
      end
    end
  end

  assign w_p_i = 19'(r_sum1_i) * 19'($signed({1'b0, r_sig1}));
  assign w_p_q = 19'(r_sum1_q) * 19'($signed({1'b0, r_sig1}));

  // S2: scale the noise by sigma and shift it down
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v2   <= 1'b0;
      r_x2_i <= '0;
      r_x2_q <= '0;
      r_n2_i <= '0;
      r_n2_q <= '0;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_x2_i <= r_x1_i;
        r_x2_q <= r_x1_q;
        r_n2_i <= (DW+2)'(w_p_i >>> NSHIFT);
        r_n2_q <= (DW+2)'(w_p_q >>> NSHIFT);
      end
    end
  end

  assign w_y_i = (DW+2)'(r_x2_i) + r_n2_i;
  assign w_y_q = (DW+2)'(r_x2_q) + r_n2_q;
  assign {w_s_i, w_c_i} = clip(w_y_i);
  assign {w_s_q, w_c_q} = clip(w_y_q);

  // S3: add noise, clip to the output range and drive the outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v3  <= 1'b0;
      r_y_i <= '0;
      r_y_q <= '0;
      r_sat <= 1'b0;
    end else if (w_adv) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_y_i <= w_c_i;
        r_y_q <= w_c_q;
        r_sat <= w_s_i | w_s_q;
      end
    end
  end

  // accepted-sample counter, sticks at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cnt <= '0;
    else if (w_acc && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
  end
endmodule
